// File: rtl/vga_timing.sv
// Raster timing generator: pixel strobe, h/v counters, blanking, syncs,
// line/frame start pulses and a free-running frame counter.
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixEn,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        lineStart,
  output logic        frameStart,
  output logic [15:0] frameCount
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] divCnt;
  logic             tick, h_wrap, v_wrap;
  logic [9:0]       h_nxt, v_nxt;

  // Next counter values; status outputs are derived from these so they
  // land in the same register stage as the counters themselves.
  always_comb begin
    tick   = (divCnt == DIV_LAST);
    h_wrap = tick && (hCount == H_LAST);
    v_wrap = h_wrap && (vCount == V_LAST);
    h_nxt  = hCount;
    v_nxt  = vCount;
    if (tick)   h_nxt = h_wrap ? 10'd0 : hCount + 10'd1;
    if (h_wrap) v_nxt = v_wrap ? 10'd0 : vCount + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt     <= '0;
      pixEn      <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      bright     <= 1'b0;
      hSync      <= ~SYNC_POL;
      vSync      <= ~SYNC_POL;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      frameCount <= '0;
    end else begin
      divCnt     <= tick ? '0 : divCnt + 1'b1;
      pixEn      <= tick;
      hCount     <= h_nxt;
      vCount     <= v_nxt;
      bright     <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hSync      <= ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vSync      <= ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      lineStart  <= h_wrap;
      frameStart <= v_wrap;
      if (v_wrap) frameCount <= frameCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: a shrunken-geometry instance (CLK_DIV=2) for full-frame
// behaviour and a default-geometry CLK_DIV=1, positive-sync instance.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: H 8/2/3/2 (total 15, sync h 10..12), V 4/1/2/1 (total 8, sync v 5..6)
  logic        a_rst, a_pix, a_br, a_hs, a_vs, a_ls, a_fs;
  logic [9:0]  a_h, a_v;
  logic [15:0] a_fc;
  // Instance B: default 640x480 geometry, CLK_DIV=1, SYNC_POL=1
  logic        b_rst, b_pix, b_br, b_hs, b_vs, b_ls, b_fs;
  logic [9:0]  b_h, b_v;
  logic [15:0] b_fc;

  vga_timing #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
               .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0))
  dut_a (.clk(clk), .reset(a_rst), .pixEn(a_pix), .hCount(a_h), .vCount(a_v),
         .bright(a_br), .hSync(a_hs), .vSync(a_vs), .lineStart(a_ls),
         .frameStart(a_fs), .frameCount(a_fc));

  vga_timing #(.CLK_DIV(1), .SYNC_POL(1'b1))
  dut_b (.clk(clk), .reset(b_rst), .pixEn(b_pix), .hCount(b_h), .vCount(b_v),
         .bright(b_br), .hSync(b_hs), .vSync(b_vs), .lineStart(b_ls),
         .frameStart(b_fs), .frameCount(b_fc));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ls_first, ls_second, ls_cnt, fs_first, fs_cnt, fc_at_fs;
    int hs_low, hs_start_h, vs_low, pix_bad, sync_bad, br_bad, fs_bad;
    logic exp_hs, exp_vs, exp_br;

    a_rst = 1'b1;
    b_rst = 1'b1;
    step(2);

    // Reset state of A
    chk("rst_pix",  a_pix, 0);
    chk("rst_h",    a_h,   0);
    chk("rst_v",    a_v,   0);
    chk("rst_br",   a_br,  0);
    chk("rst_hs",   a_hs,  1);
    chk("rst_vs",   a_vs,  1);
    chk("rst_ls",   a_ls,  0);
    chk("rst_fs",   a_fs,  0);
    chk("rst_fc",   a_fc,  0);
    chk("rst_b_hs", b_hs,  0);

    // Divider: first edges after release
    a_rst = 1'b0;
    step(1);
    chk("e1_pix", a_pix, 0);
    chk("e1_h",   a_h,   0);
    chk("e1_br",  a_br,  1);
    chk("e1_ls",  a_ls,  0);
    step(1);
    chk("e2_pix", a_pix, 1);
    chk("e2_h",   a_h,   1);
    step(1);
    chk("e3_pix", a_pix, 0);
    chk("e3_h",   a_h,   1);

    // Two full frames of A, edges 4..480; line = 30 clks, frame = 240 clks
    ls_first = -1; ls_second = -1; ls_cnt = 0; fs_first = -1; fs_cnt = 0;
    fc_at_fs = -1; hs_low = 0; hs_start_h = -1; vs_low = 0;
    pix_bad = 0; sync_bad = 0; br_bad = 0; fs_bad = 0;
    for (int e = 4; e <= 480; e++) begin
      step(1);
      if (a_pix !== ((e % 2) == 0)) pix_bad++;
      exp_hs = !((a_h >= 10) && (a_h <= 12));
      exp_vs = !((a_v >= 5) && (a_v <= 6));
      exp_br = (a_h < 8) && (a_v < 4);
      if (a_hs !== exp_hs || a_vs !== exp_vs) sync_bad++;
      if (a_br !== exp_br) br_bad++;
      if (a_ls === 1'b1) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = e;
        else if (ls_second < 0) ls_second = e;
      end
      if (a_fs === 1'b1) begin
        fs_cnt++;
        if (a_ls !== 1'b1 || a_h !== 0 || a_v !== 0) fs_bad++;
        if (fs_first < 0) begin
          fs_first = e;
          fc_at_fs = a_fc;
        end
      end
      if (e < 30 && a_hs === 1'b0) begin
        hs_low++;
        if (hs_start_h < 0) hs_start_h = a_h;
      end
      if (e < 240 && a_vs === 1'b0) vs_low++;
    end
    chk("pix_pattern",  pix_bad,    0);
    chk("sync_decode",  sync_bad,   0);
    chk("bright_area",  br_bad,     0);
    chk("ls_first",     ls_first,   30);
    chk("ls_period",    ls_second - ls_first, 30);
    chk("ls_count",     ls_cnt,     16);
    chk("hs_low_clks",  hs_low,     6);
    chk("hs_start_h",   hs_start_h, 10);
    chk("vs_low_clks",  vs_low,     60);
    chk("fs_first",     fs_first,   240);
    chk("fs_count",     fs_cnt,     2);
    chk("fs_align",     fs_bad,     0);
    chk("fc_first",     fc_at_fs,   1);
    chk("fc_two",       a_fc,       2);

    // Mid-frame reset inside both sync regions: h=11, v=5 at edge 652
    step(172);
    chk("pre_h",  a_h,  11);
    chk("pre_v",  a_v,  5);
    chk("pre_hs", a_hs, 0);
    chk("pre_vs", a_vs, 0);
    a_rst = 1'b1;
    step(1);
    chk("mid_h",  a_h,  0);
    chk("mid_v",  a_v,  0);
    chk("mid_hs", a_hs, 1);
    chk("mid_vs", a_vs, 1);
    chk("mid_fc", a_fc, 0);
    chk("mid_ls", a_ls, 0);
    chk("mid_fs", a_fs, 0);
    a_rst = 1'b0;
    step(1);
    chk("post_h",  a_h,  0);
    chk("post_br", a_br, 1);
    chk("post_ls", a_ls, 0);
    chk("post_fs", a_fs, 0);
    chk("post_fc", a_fc, 0);

    // Instance B: pixEn always high, 800-clk lines, positive sync on h 656..751
    b_rst = 1'b0;
    ls_first = -1; ls_second = -1; ls_cnt = 0; hs_low = 0;
    pix_bad = 0; sync_bad = 0; br_bad = 0;
    for (int e = 1; e <= 1600; e++) begin
      step(1);
      if (b_pix !== 1'b1) pix_bad++;
      exp_hs = (b_h >= 656) && (b_h <= 751);
      if (b_hs !== exp_hs || b_vs !== 1'b0) sync_bad++;
      if (b_br !== ((b_h < 640) && (b_v < 480))) br_bad++;
      if (b_ls === 1'b1) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = e;
        else if (ls_second < 0) ls_second = e;
      end
      if (e < 800 && b_hs === 1'b1) hs_low++;
    end
    chk("b_pix_const",  pix_bad,  0);
    chk("b_sync",       sync_bad, 0);
    chk("b_bright",     br_bad,   0);
    chk("b_ls_first",   ls_first, 800);
    chk("b_ls_period",  ls_second - ls_first, 800);
    chk("b_ls_count",   ls_cnt,   2);
    chk("b_hs_clks",    hs_low,   96);
    chk("b_v_end",      b_v,      2);
    chk("b_fs_none",    b_fs,     0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
